// File: rtl/input_debounce.sv
// Pin-side conditioning for push-buttons and slide-switches: polarity fix, 2-flop sync,
// per-bit stability-counter debounce, key press pulses, sticky pending flags and irq.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter bit SW_ACTIVE_LOW   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] raw_keys,
  input  logic [3:0] raw_switches,
  output logic [3:0] keys,
  output logic [3:0] switches,
  output logic [3:0] key_press,
  output logic [3:0] key_pending,
  input  logic       clear_en,
  input  logic [3:0] clear_mask,
  output logic       irq
);

  localparam logic [3:0] KEY_INV = KEY_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [3:0] SW_INV  = SW_ACTIVE_LOW  ? 4'hF : 4'h0;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Bits [3:0] are keys, bits [7:4] are switches; all active-high from here on.
  logic [7:0] cond_in;
  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] stable;
  logic [7:0] stable_next;
  logic [3:0] rise;
  logic [3:0] clr;
  logic [CNT_WIDTH-1:0] cnt      [8];
  logic [CNT_WIDTH-1:0] cnt_next [8];

  assign cond_in = {raw_switches ^ SW_INV, raw_keys ^ KEY_INV};

  always_comb begin
    stable_next = stable;
    for (int i = 0; i < 8; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // A press is a debounced 0->1 on a key; computed from next state so the pulse and
  // the debounced key become visible on the same edge.
  assign rise = stable_next[3:0] & ~stable[3:0];
  assign clr  = clear_en ? clear_mask : 4'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      stable      <= '0;
      key_press   <= '0;
      key_pending <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1       <= cond_in;
      sync2       <= sync1;
      stable      <= stable_next;
      key_press   <= rise;
      // Set has priority over a simultaneous clear.
      key_pending <= (key_pending & ~clr) | rise;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign keys     = stable[3:0];
  assign switches = stable[7:4];
  assign irq      = |key_pending;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with DEBOUNCE_CYCLES=4: a vector table for reset,
// press and bounce rejection, then hand-written sequences for clear, switches and reset.
module tb_input_debounce;

  logic       clk;
  logic       reset;
  logic [3:0] raw_keys;
  logic [3:0] raw_switches;
  logic [3:0] keys;
  logic [3:0] switches;
  logic [3:0] key_press;
  logic [3:0] key_pending;
  logic       clear_en;
  logic [3:0] clear_mask;
  logic       irq;

  int n_cmp;
  int n_err;

  typedef struct {
    logic       rst;
    logic [3:0] rk;
    logic [3:0] rs;
    logic [3:0] e_keys;
    logic [3:0] e_sw;
    logic [3:0] e_press;
    logic [3:0] e_pend;
    logic       e_irq;
  } vec_t;

  vec_t vecs[$];

  input_debounce #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(16),
    .KEY_ACTIVE_LOW(1'b1),
    .SW_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_keys(raw_keys),
    .raw_switches(raw_switches),
    .keys(keys),
    .switches(switches),
    .key_press(key_press),
    .key_pending(key_pending),
    .clear_en(clear_en),
    .clear_mask(clear_mask),
    .irq(irq)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp4(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check(input string tag, input logic [3:0] e_keys, input logic [3:0] e_sw,
                       input logic [3:0] e_press, input logic [3:0] e_pend, input logic e_irq);
    cmp4({tag, ".keys"}, keys, e_keys);
    cmp4({tag, ".switches"}, switches, e_sw);
    cmp4({tag, ".key_press"}, key_press, e_press);
    cmp4({tag, ".key_pending"}, key_pending, e_pend);
    cmp4({tag, ".irq"}, {3'b0, irq}, {3'b0, e_irq});
  endtask

  task automatic add(input logic rst, input logic [3:0] rk, input logic [3:0] rs,
                     input logic [3:0] ek, input logic [3:0] es, input logic [3:0] ep,
                     input logic [3:0] epd, input logic ei);
    vec_t v;
    v.rst = rst; v.rk = rk; v.rs = rs;
    v.e_keys = ek; v.e_sw = es; v.e_press = ep; v.e_pend = epd; v.e_irq = ei;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic [3:0] rk, input logic [3:0] rs,
                       input logic ce, input logic [3:0] cm);
    reset        = rst;
    raw_keys     = rk;
    raw_switches = rs;
    clear_en     = ce;
    clear_mask   = cm;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    drive(1'b1, 4'hF, 4'h0, 1'b0, 4'h0);

    // Test 1: reset held 10 cycles with keys released.
    for (int i = 0; i < 10; i++) add(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    // Test 2: key 0 pressed before edge 1, visible after edge 6, pulse one cycle.
    for (int i = 1; i <= 5; i++) add(1'b0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    add(1'b0, 4'hE, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 1'b1);
    add(1'b0, 4'hE, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1);
    add(1'b0, 4'hE, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1);
    // Test 3: key 1 low 3 cycles, high 1, then low steady from edge N; rises after N+5.
    for (int i = 0; i < 3; i++) add(1'b0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1);
    add(1'b0, 4'hE, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1);
    for (int i = 0; i < 5; i++) add(1'b0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1);
    add(1'b0, 4'hC, 4'h0, 4'h3, 4'h0, 4'h2, 4'h3, 1'b1);
    add(1'b0, 4'hC, 4'h0, 4'h3, 4'h0, 4'h0, 4'h3, 1'b1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rk, vecs[i].rs, 1'b0, 4'h0);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_keys, vecs[i].e_sw, vecs[i].e_press,
            vecs[i].e_pend, vecs[i].e_irq);
    end

    // Test 4: masked clears, then set coinciding with clear on the same bit.
    drive(1'b0, 4'hC, 4'h0, 1'b1, 4'h2);
    step();
    check("clr_k1", 4'h3, 4'h0, 4'h0, 4'h1, 1'b1);
    drive(1'b0, 4'hC, 4'h0, 1'b1, 4'h1);
    step();
    check("clr_k0", 4'h3, 4'h0, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h8, 4'h0, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) step();
    check("k2_wait", 4'h3, 4'h0, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h8, 4'h0, 1'b1, 4'h4);
    step();
    check("set_wins", 4'h7, 4'h0, 4'h4, 4'h4, 1'b1);
    drive(1'b0, 4'h8, 4'h0, 1'b0, 4'h0);
    step();
    check("set_hold", 4'h7, 4'h0, 4'h0, 4'h4, 1'b1);

    // Test 5: switches debounce without events; key 0 release generates none.
    drive(1'b0, 4'h9, 4'hA, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) step();
    check("sw_wait", 4'h7, 4'h0, 4'h0, 4'h4, 1'b1);
    step();
    check("sw_on", 4'h6, 4'hA, 4'h0, 4'h4, 1'b1);
    step();
    check("sw_hold", 4'h6, 4'hA, 4'h0, 4'h4, 1'b1);
    drive(1'b0, 4'h9, 4'hA, 1'b1, 4'hF);
    step();
    check("clr_all", 4'h6, 4'hA, 4'h0, 4'h0, 1'b0);

    // Test 6: reset mid-count (key-0 counter at 2), then held keys re-debounce.
    drive(1'b0, 4'h8, 4'hA, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) step();
    check("pre_rst", 4'h6, 4'hA, 4'h0, 4'h0, 1'b0);
    drive(1'b1, 4'h8, 4'hA, 1'b0, 4'h0);
    step();
    check("mid_rst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h8, 4'hA, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) step();
    check("post_wait", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step();
    check("post_rise", 4'h7, 4'hA, 4'h7, 4'h7, 1'b1);
    step();
    check("post_hold", 4'h7, 4'hA, 4'h0, 4'h7, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
Pin-side conditioning stage between the board's raw push-buttons/slide-switches and the processor IO controller. Each input is synchronised into clk, debounced with a per-bit stability counter, and converted to active-high.
- keys and switches drive the IO controller's key/switch inputs directly.
- Key press events are also captured as one-cycle pulses and sticky pending flags, and are ORed into an interrupt request.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a debounced output changes; legal range 1..2^CNT_WIDTH
CNT_WIDTH, 16, width of each per-bit stability counter
KEY_ACTIVE_LOW, 1, 1 = raw_keys are active-low (inverted before synchronising); 0 = active-high
SW_ACTIVE_LOW, 0, same for raw_switches

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
raw_keys  input  4  asynchronous push-button pins
raw_switches  input  4  asynchronous slide-switch pins
keys  output  4  debounced keys, 1 = pressed
switches  output  4  debounced switches, 1 = on
key_press  output  4  one-cycle pulse per key on a debounced 0->1 transition
key_pending  output  4  sticky press flags
clear_en  input  1  clear strobe for key_pending
clear_mask  input  4  bits of key_pending cleared when clear_en=1
irq  output  1  OR of key_pending

Behaviour:
- Reset (clk edge with reset=1):
  - sync stages, counters, keys, switches, key_press and key_pending all go to 0; irq=0.
  - Reset has priority over all other activity, including a count in progress; the count restarts from 0.
- Polarity: inversion per KEY_ACTIVE_LOW/SW_ACTIVE_LOW is applied before the first sync flop. All internal and output values are active-high.
- Synchroniser: two flops per bit (sync1, sync2). Only sync2 is used downstream.
- Debounce, per bit, with stable = the corresponding keys/switches bit:
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
  - Any single cycle in which sync2 returns to the stable value restarts the count, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Latency: a clean raw change sampled at edge 1 appears on keys/switches after edge DEBOUNCE_CYCLES+2.
- key_press[i]:
  - Registered. High for exactly one cycle: the first cycle in which keys[i] reads 1 after being 0.
  - Key release generates no event.
  - Switches never generate events.
- key_pending[i]:
  - Set at the same edge key_press[i] is asserted.
  - Cleared at an edge where clear_en=1 and clear_mask[i]=1.
  - Simultaneous set and clear on the same bit: set wins and the bit stays 1.
  - Bits not selected by clear_mask are unaffected.
- irq: combinational OR of the key_pending register bits. It has no extra latency relative to key_pending.
- A key held through reset is seen as 0 at reset release. It then debounces to 1 after DEBOUNCE_CYCLES+2 cycles and produces a normal key_press.
- Counters saturate logically at DEBOUNCE_CYCLES-1 via the compare; they never wrap.

Test Plan:
(All tests use DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1, SW_ACTIVE_LOW=0.)
1. Reset with raw_keys=4'hF, raw_switches=0, held 10 cycles -> keys=0, switches=0, key_press=0, key_pending=0, irq=0 throughout.
2. raw_keys=4'hE applied cleanly just before edge 1 -> keys=4'h1 and key_press=4'h1 first visible after edge 6. key_press returns to 0 after edge 7; key_pending=4'h1 and irq=1 from edge 6 onward.
3. Bounce on raw_keys[1]: low 3 cycles, high 1, then low steady from edge N -> keys[1] rises after edge N+5, exactly one key_press[1] pulse, no earlier transition.
4. With key_pending=4'h1: clear_en=1, clear_mask=4'h1 -> key_pending=0, irq=0 next cycle. Then a key_press[2] edge coinciding with clear_en=1, clear_mask=4'h4 -> key_pending=4'h4, irq=1.
5. raw_switches=4'hA -> switches=4'hA after edge 6. key_press and key_pending remain 0. Releasing key 0 (raw_keys=4'hF) drops keys[0] after 6 edges with no event.
6. Reset asserted for 1 cycle when the key-0 counter is at 2 -> all outputs 0. With raw key still pressed, keys[0] rises DEBOUNCE_CYCLES+2 edges after reset deasserts, with a fresh key_press[0].
